// File: rtl/pulse_gate_ctl_if.sv
// Result handshake bundle of pulse_gate_ctl: the measured count and overflow
// flag, qualified by valid/ready.
interface pulse_gate_ctl_if #(
   parameter int CNT_BITS = 16
) ();
   logic                o_valid;
   logic                i_ready;
   logic [CNT_BITS-1:0] o_data;
   logic                o_ovf;

   modport master (output o_valid, output o_data, output o_ovf, input i_ready);
   modport slave  (input o_valid, input o_data, input o_ovf, output i_ready);
endinterface

// File: rtl/pulse_gate_ctl.sv
// Gated pulse-measurement controller: counts rising edges of i_cnt over a window
// of i_window clocks and hands the count over valid/ready. PULSE_GATE_SAT_EN selects saturation.
module pulse_gate_ctl #(
   parameter int CNT_BITS = 16,
   parameter int WIN_BITS = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_cnt,
   input  logic [WIN_BITS-1:0] i_window,
   input  logic                i_start,
   input  logic                i_abort,
   output logic                o_busy,
   pulse_gate_ctl_if.master    res
);

   typedef enum logic [1:0] {ST_IDLE, ST_GATE, ST_HOLD} state_t;

   state_t              r_state;
   logic                r_cnt;
   logic [WIN_BITS-1:0] r_rem;
   logic [CNT_BITS-1:0] r_work;
   logic [CNT_BITS-1:0] r_data;
   logic                r_busy;
   logic                r_valid;
`ifdef PULSE_GATE_SAT_EN
   logic                r_sat_ovf;
   logic                r_ovf;
   logic                w_ovf_nxt;
`endif

   logic                w_edge;
   logic                w_accept;
   logic                w_last;
   logic [CNT_BITS-1:0] w_work_nxt;

   assign w_edge   = !r_cnt && i_cnt;
   assign w_last   = (r_rem == WIN_BITS'(1));
   // A result being consumed can restart the gate in the same edge.
   assign w_accept = !i_abort && i_start &&
                     ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && res.i_ready));

   always_comb begin
      w_work_nxt = r_work;
`ifdef PULSE_GATE_SAT_EN
      w_ovf_nxt  = r_sat_ovf;
      if (w_edge) begin
         if (&r_work) w_ovf_nxt  = 1'b1;
         else         w_work_nxt = r_work + CNT_BITS'(1);
      end
`else
      if (w_edge) w_work_nxt = r_work + CNT_BITS'(1);
`endif
   end

   // NOTE: non-blocking assignments for all state; the reset is synchronous, so
   // it is just the first branch inside the clocked block.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 1'b0;
         r_rem     <= '0;
         r_work    <= '0;
         r_data    <= '0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
`ifdef PULSE_GATE_SAT_EN
         r_sat_ovf <= 1'b0;
         r_ovf     <= 1'b0;
`endif
      end else begin
         r_cnt <= i_cnt;
         if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_rem   <= '0;
            r_work  <= '0;
         end else if (w_accept) begin
            r_rem     <= i_window;
            r_work    <= '0;
`ifdef PULSE_GATE_SAT_EN
            r_sat_ovf <= 1'b0;
`endif
            if (i_window == '0) begin
               r_state <= ST_HOLD;
               r_busy  <= 1'b0;
               r_valid <= 1'b1;
               r_data  <= '0;
`ifdef PULSE_GATE_SAT_EN
               r_ovf   <= 1'b0;
`endif
            end else begin
               r_state <= ST_GATE;
               r_busy  <= 1'b1;
               r_valid <= 1'b0;
            end
         end else begin
            case (r_state)
               ST_GATE: begin
                  r_work    <= w_work_nxt;
                  r_rem     <= r_rem - WIN_BITS'(1);
`ifdef PULSE_GATE_SAT_EN
                  r_sat_ovf <= w_ovf_nxt;
`endif
                  if (w_last) begin
                     r_data  <= w_work_nxt;
`ifdef PULSE_GATE_SAT_EN
                     r_ovf   <= w_ovf_nxt;
`endif
                     r_state <= ST_HOLD;
                     r_busy  <= 1'b0;
                     r_valid <= 1'b1;
                  end
               end
               ST_HOLD: begin
                  if (res.i_ready) begin
                     r_state <= ST_IDLE;
                     r_valid <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_busy      = r_busy;
   assign res.o_valid = r_valid;
   assign res.o_data  = r_data;
`ifdef PULSE_GATE_SAT_EN
   assign res.o_ovf   = r_ovf;
`else
   assign res.o_ovf   = 1'b0;
`endif

endmodule
